// File: rtl/requant_pipe.sv
// Two-stage requantiser: per-channel round-half-to-even right shift, then symmetric clamp.
// Stages advance together; a sticky flag and a saturating counter track beats that were clamped.
module requant_pipe #(
  parameter int IN_WIDTH    = 9,
  parameter int OUT_WIDTH   = 6,
  parameter int CHANNELS    = 2,
  parameter int BASE_SHIFT  = 3,
  parameter int SHIFT_WIDTH = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0]  in_data,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0] out_data,
  input  logic                          sat_clear,
  output logic [CNT_WIDTH-1:0]          sat_cnt,
  output logic                          sat_flag
);

  // One guard bit above the input so the rounding carry can never wrap.
  localparam int W1 = IN_WIDTH + 1;
  localparam logic signed [W1-1:0] MAX_OUT = W1'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [W1-1:0] MIN_OUT = -MAX_OUT;

  logic                          en;
  logic [7:0]                    s_amt;
  logic [CHANNELS*W1-1:0]        rnd_all;
  logic [CHANNELS*W1-1:0]        s1_data;
  logic                          s1_valid;
  logic [CHANNELS*OUT_WIDTH-1:0] clamp_all;
  logic                          any_sat;
  logic                          sat_load;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign s_amt    = 8'(BASE_SHIFT) + 8'(shift_i);
  assign sat_load = en & s1_valid & any_sat;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : round_stage
    logic signed [W1-1:0] xe;
    logic signed [W1-1:0] q;
    logic [W1-1:0]        hbit;
    logic [W1-1:0]        mask;
    logic                 half;
    logic                 sticky;
    logic                 carry;
    rnd_all = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      xe     = {in_data[ch*IN_WIDTH+IN_WIDTH-1], in_data[ch*IN_WIDTH +: IN_WIDTH]};
      q      = xe >>> s_amt;
      hbit   = '0;
      mask   = '0;
      half   = 1'b0;
      sticky = 1'b0;
      if (s_amt != 8'd0) begin
        hbit   = W1'(1) << (s_amt - 8'd1);
        mask   = hbit - W1'(1);
        half   = |(xe & hbit);
        sticky = |(xe & mask);
      end
      carry = half & (q[0] | sticky);
      rnd_all[ch*W1 +: W1] = q + W1'(carry);
    end
  end

  // -2^(OUT_WIDTH-1) is clamped too, so the output range stays symmetric.
  always_comb begin : clamp_stage
    logic signed [W1-1:0] r;
    clamp_all = '0;
    any_sat   = 1'b0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      r = s1_data[ch*W1 +: W1];
      if (r > MAX_OUT) begin
        r       = MAX_OUT;
        any_sat = 1'b1;
      end else if (r < MIN_OUT) begin
        r       = MIN_OUT;
        any_sat = 1'b1;
      end
      clamp_all[ch*OUT_WIDTH +: OUT_WIDTH] = r[OUT_WIDTH-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_cnt   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (en) begin
        s1_valid  <= in_valid;
        s1_data   <= rnd_all;
        out_valid <= s1_valid;
        if (s1_valid) out_data <= clamp_all;
      end
      if (sat_clear) begin
        sat_cnt  <= sat_load ? CNT_WIDTH'(1) : '0;
        sat_flag <= sat_load;
      end else if (sat_load) begin
        sat_flag <= 1'b1;
        if (sat_cnt != '1) sat_cnt <= sat_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_requant_pipe.sv
// Directed bench for requant_pipe: rounding, clamping, shift range, backpressure,
// counter saturation/clear and mid-stream reset, with hand-computed expectations.
module tb_requant_pipe;

  localparam int IW = 9;
  localparam int OW = 6;
  localparam int CH = 2;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [CH*IW-1:0] in_data;
  logic [1:0]      shift_i;
  logic            out_valid;
  logic            out_ready;
  logic [CH*OW-1:0] out_data;
  logic            sat_clear;
  logic [CW-1:0]   sat_cnt;
  logic            sat_flag;

  int passed = 0;
  int total  = 0;
  logic collect = 1'b0;
  logic [CH*OW-1:0] got[$];

  requant_pipe #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .CHANNELS(CH),
    .BASE_SHIFT(3), .SHIFT_WIDTH(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .shift_i(shift_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_clear(sat_clear), .sat_cnt(sat_cnt), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (collect && out_valid && out_ready) got.push_back(out_data);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [CH*IW-1:0] pack_in(input int a, input int b);
    return {b[IW-1:0], a[IW-1:0]};
  endfunction

  function automatic logic [CH*OW-1:0] pack_out(input int a, input int b);
    return {b[OW-1:0], a[OW-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, then wait (bounded) for it and compare.
  task automatic run_beat(input int x0, input int x1, input int sh,
                          input int e0, input int e1, input string tag);
    int n;
    in_valid = 1'b1;
    in_data  = pack_in(x0, x1);
    shift_i  = sh[1:0];
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 5) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, 1);
    check({tag, " data"}, out_data, pack_out(e0, e1));
  endtask

  initial begin
    int k;
    int cyc;
    logic acc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    shift_i   = '0;
    out_ready = 1'b1;
    sat_clear = 1'b0;
    tick();
    tick();
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset sat_cnt", sat_cnt, 0);
    check("reset sat_flag", sat_flag, 0);
    reset = 1'b0;
    tick();
    check("in_ready after reset", in_ready, 1);

    // Rounding, half to even, s = 3.
    run_beat(20, 28, 0, 2, 4, "round 20/28");
    run_beat(21, 12, 0, 3, 2, "round 21/12");
    run_beat(-20, -28, 0, -2, -4, "round -20/-28");
    check("no sat cnt", sat_cnt, 0);
    check("no sat flag", sat_flag, 0);

    // Saturation, including the exact -32 case.
    run_beat(255, 0, 0, 31, 0, "sat +255");
    run_beat(0, -256, 0, 0, -31, "sat -256");
    check("sat cnt 2", sat_cnt, 2);
    check("sat flag", sat_flag, 1);

    // Maximum shift (s = 6).
    run_beat(255, -96, 3, 4, -2, "shift3");
    check("shift no sat", sat_cnt, 2);

    // Backpressure: continuous stream, out_ready low for cycles 4..6.
    in_valid = 1'b0;
    tick();
    collect = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 40) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = 1'b1;
      in_data   = pack_in(8 * (k + 1), -8 * (k + 1));
      shift_i   = 2'd0;
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        check("bp stall in_ready", in_ready, 0);
        check("bp stall valid", out_valid, 1);
        check("bp hold data", out_data, pack_out(3, -3));
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    check("bp all sent", k, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    collect = 1'b0;
    check("bp beat count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check("bp order", got[i], pack_out(i + 1, -(i + 1)));

    // Counter clear and saturation at all-ones.
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    check("clear cnt", sat_cnt, 0);
    check("clear flag", sat_flag, 0);
    for (int i = 0; i < 5; i++) run_beat(255, 255, 0, 31, 31, "sat5");
    check("cnt held at max", sat_cnt, 3);
    check("cnt flag", sat_flag, 1);

    // Clear coincident with a saturating load.
    in_valid = 1'b1;
    in_data  = pack_in(255, 0);
    shift_i  = 2'd0;
    tick();
    in_valid  = 1'b0;
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    check("coincident valid", out_valid, 1);
    check("coincident cnt", sat_cnt, 1);
    check("coincident flag", sat_flag, 1);

    // Reset with two saturating beats in flight.
    in_valid = 1'b1;
    in_data  = pack_in(255, 255);
    tick();
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check("mid reset valid", out_valid, 0);
    check("mid reset cnt", sat_cnt, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post reset no beat", out_valid, 0);
    end
    check("post reset in_ready", in_ready, 1);
    check("post reset cnt", sat_cnt, 0);
    check("post reset flag", sat_flag, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/requant_pipe.md
REQUANT_PIPE -- requirements
Module: requant_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 9: signed input sample width per channel.
REQ-002 SHALL have parameter OUT_WIDTH, default 6: signed output sample width per channel.
REQ-003 SHALL have parameter CHANNELS, default 2: channels packed per beat (ch0 in LSBs).
REQ-004 SHALL have parameter BASE_SHIFT, default 3: fixed minimum right shift.
REQ-005 SHALL have parameter SHIFT_WIDTH, default 2: width of shift_i.
REQ-006 SHALL have parameter CNT_WIDTH, default 16: saturation counter width.
REQ-007 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-008 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port in_valid  input  1  input beat valid.
REQ-010 SHALL have port in_ready  output  1  input beat accepted when in_valid & in_ready.
REQ-011 SHALL have port in_data  input  CHANNELS*IN_WIDTH  two's-complement samples.
REQ-012 SHALL have port shift_i  input  SHIFT_WIDTH  per-beat extra shift, sampled with in_data.
REQ-013 SHALL have port out_valid  output  1  output beat valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-015 SHALL have port out_data  output  CHANNELS*OUT_WIDTH  requantised samples.
REQ-016 SHALL have port sat_clear  input  1  synchronous clear of sat_cnt and sat_flag.
REQ-017 SHALL have port sat_cnt  output  CNT_WIDTH  count of beats with any channel saturated.
REQ-018 SHALL have port sat_flag  output  1  sticky: at least one saturation since last clear.

Function
REQ-019 SHALL compute per channel y = round(x / 2^s), s = BASE_SHIFT + shift_i, rounding half to even (carry = bit[s-1] & (bit[s] | OR of bits[s-2:0])).
REQ-020 SHALL perform shift/round in a width of IN_WIDTH+1 bits so carry never wraps.
REQ-021 SHALL clamp y symmetrically to [-(2^(OUT_WIDTH-1)-1), +(2^(OUT_WIDTH-1)-1)]; -2^(OUT_WIDTH-1) is never output.
REQ-022 SHALL mark a channel saturated when clamping changed its value (including exact -2^(OUT_WIDTH-1)).
REQ-023 SHALL be a 2-stage pipeline: stage 1 registers shift+round result and per-beat shift; stage 2 registers clamped out_data, out_valid, beat saturation bit.
REQ-024 SHALL have latency 2 cycles from accepted input to out_valid with out_ready held high; throughput 1 beat/cycle.
REQ-025 SHALL use global stall: en = ~out_valid | out_ready; in_ready = en; both stages advance only when en.
REQ-026 SHALL hold out_data and out_valid stable while out_valid & ~out_ready.
REQ-027 SHALL propagate bubbles (stage-1 invalid) as out_valid=0; bubbles not collapsed.
REQ-028 SHALL increment sat_cnt by 1 on each stage-2 load of a valid beat with any channel saturated; sat_cnt holds at all-ones (no wrap).
REQ-029 SHALL set sat_flag on the same event; it stays set until sat_clear or reset.
REQ-030 SHALL on sat_clear coincident with a saturating load give sat_cnt=1, sat_flag=1; sat_clear alone gives 0/0.
REQ-031 SHALL apply shift_i per beat; changing shift_i between beats needs no flush.

Reset
REQ-032 SHALL on reset: out_valid=0, stage-1 valid=0, out_data=0, sat_cnt=0, sat_flag=0; in_ready=1 in the cycle after reset deasserts.
REQ-033 SHALL on reset mid-stream discard all in-flight beats; none emitted after reset.
REQ-034 SHALL give reset priority over sat_clear and handshakes.

Verification
REQ-035 SHALL cover rounding, defaults, shift_i=0: x=+20->2, +28->4, +21->3, +12->2, -20->-2, -28->-4; sat_cnt stays 0.
REQ-036 SHALL cover saturation: x=+255, shift_i=0 -> +31; x=-256, shift_i=0 -> -31; sat_cnt=2, sat_flag=1.
REQ-037 SHALL cover shift range: x=+255, shift_i=3 (s=6) -> +4; x=-96, shift_i=3 -> -2 (half to even); no saturation.
REQ-038 SHALL cover backpressure: continuous input, out_ready low 3 cycles mid-stream -> out_data held, in_ready=0 while stalled, no beat lost/duplicated, order preserved.
REQ-039 SHALL cover counter edges: CNT_WIDTH=2 with 5 saturating beats -> sat_cnt=3; sat_clear with saturating beat -> sat_cnt=1.
REQ-040 SHALL cover reset with 2 beats in flight -> out_valid=0 next cycle, no stale beats, sat_cnt=0.
